// File: rtl/less_cmp_pipe.sv
// less_cmp_pipe: pipelined a<b / a<=b compare, MSB chunk first, valid/ready.
// Optional CMP_DIFF_EN adds a piped (WIDTH+1)-bit a-b output port diff.
module less_cmp_pipe #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lt,
    output logic             eq,
    output logic             c
`ifdef CMP_DIFF_EN
    ,
    output logic [WIDTH:0]   diff
`endif
);
    localparam int STAGES = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int PW     = STAGES * CHUNK;

    logic          stall;
    logic [PW-1:0] a_in [STAGES];
    logic [PW-1:0] b_in [STAGES];
    logic [1:0]    m_in [STAGES];
    logic          v_in [STAGES];
    logic          d_in [STAGES];
    logic          l_in [STAGES];
    logic          d_nx [STAGES];
    logic          l_nx [STAGES];
    logic [PW-1:0] a_q  [STAGES];
    logic [PW-1:0] b_q  [STAGES];
    logic [1:0]    m_q  [STAGES];
    logic          v_q  [STAGES];
    logic          d_q  [STAGES];
    logic          l_q  [STAGES];
    logic          last_lt;
    logic          last_eq;

    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = v_q[STAGES-1];
    assign last_lt   = l_nx[STAGES-1];
    assign last_eq   = !d_nx[STAGES-1];

    // Stage inputs: biased, zero-padded operands for stage 0, upstream register otherwise
    always_comb begin
        a_in[0] = '0;
        b_in[0] = '0;
        a_in[0][WIDTH-1:0] = {a[WIDTH-1] ^ mode[1], a[WIDTH-2:0]};
        b_in[0][WIDTH-1:0] = {b[WIDTH-1] ^ mode[1], b[WIDTH-2:0]};
        m_in[0] = mode;
        v_in[0] = in_valid;
        d_in[0] = 1'b0;
        l_in[0] = 1'b0;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            m_in[k] = m_q[k-1];
            v_in[k] = v_q[k-1];
            d_in[k] = d_q[k-1];
            l_in[k] = l_q[k-1];
        end
    end

    // Each stage settles the verdict on its chunk unless a higher chunk already did
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            d_nx[k] = d_in[k];
            l_nx[k] = l_in[k];
            if (!d_in[k]) begin
                if (a_in[k][(STAGES-1-k)*CHUNK +: CHUNK] <
                    b_in[k][(STAGES-1-k)*CHUNK +: CHUNK]) begin
                    d_nx[k] = 1'b1;
                    l_nx[k] = 1'b1;
                end else if (a_in[k][(STAGES-1-k)*CHUNK +: CHUNK] >
                             b_in[k][(STAGES-1-k)*CHUNK +: CHUNK]) begin
                    d_nx[k] = 1'b1;
                    l_nx[k] = 1'b0;
                end
            end
        end
    end

    // Pipeline registers and result flops, all frozen together on a stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                m_q[k] <= '0;
                d_q[k] <= 1'b0;
                l_q[k] <= 1'b0;
            end
            lt <= 1'b0;
            eq <= 1'b0;
            c  <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_in[k];
                if (v_in[k]) begin
                    a_q[k] <= a_in[k];
                    b_q[k] <= b_in[k];
                    m_q[k] <= m_in[k];
                    d_q[k] <= d_nx[k];
                    l_q[k] <= l_nx[k];
                end
            end
            if (v_in[STAGES-1]) begin
                lt <= last_lt;
                eq <= last_eq;
                c  <= m_in[STAGES-1][0] ? (last_lt | last_eq) : last_lt;
            end
        end
    end

`ifdef CMP_DIFF_EN
    logic [WIDTH:0] df_in [STAGES];
    logic [WIDTH:0] df_q  [STAGES];

    assign diff = df_q[STAGES-1];

    // Difference uses sign extension only for signed beats
    always_comb begin
        df_in[0] = {mode[1] & a[WIDTH-1], a} - {mode[1] & b[WIDTH-1], b};
        for (int k = 1; k < STAGES; k++) begin
            df_in[k] = df_q[k-1];
        end
    end

    // Difference travels with its beat under the same enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                df_q[k] <= '0;
            end
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                if (v_in[k]) begin
                    df_q[k] <= df_in[k];
                end
            end
        end
    end
`endif

endmodule
